// File: rtl/frec_selector_pkg.sv
// Shared definitions for the frequency selector: data widths, BCD converter
// states, default timing constants and the double-dabble digit correction.
package frec_selector_pkg;

    localparam int FREC_W = 8;
    localparam int BCD_W  = 4;

    // Default timing at 100 MHz
    localparam int unsigned DEF_DEBOUNCE_CYCLES = 1_000_000;   // 10 ms
    localparam int unsigned DEF_REPEAT_DELAY    = 50_000_000;  // 0.5 s
    localparam int unsigned DEF_REPEAT_RATE     = 10_000_000;  // 0.1 s

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SHIFT,
        ST_DONE
    } bcd_state_t;

    // Double-dabble correction: a digit of 5 or more gets +3 before the shift
    function automatic logic [BCD_W-1:0] dabble_adjust(input logic [BCD_W-1:0] d);
        return (d >= 4'd5) ? d + 4'd3 : d;
    endfunction

endpackage

// File: rtl/frec_selector_btn_debounce.sv
// Raw push-button conditioning: two-flop synchronizer, counter debounce and
// a one-cycle pulse on the rising edge of the accepted level.
module btn_debounce
    import frec_selector_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic level,
    output logic rise
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_reg;
    logic             sync2_reg;
    logic [CNT_W-1:0] cnt_reg;

    // Bring the asynchronous button into the clk domain
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_reg <= 1'b0;
            sync2_reg <= 1'b0;
        end else begin
            sync1_reg <= btn;
            sync2_reg <= sync1_reg;
        end
    end

    // Accept a new level only after it disagrees for DEBOUNCE_CYCLES cycles in a row;
    // rise is registered together with the level so both appear in the same cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            level   <= 1'b0;
            rise    <= 1'b0;
            cnt_reg <= '0;
        end else begin
            rise <= 1'b0;
            if (sync2_reg != level) begin
                if (cnt_reg == CNT_LAST) begin
                    level   <= sync2_reg;
                    rise    <= sync2_reg;
                    cnt_reg <= '0;
                end else begin
                    cnt_reg <= cnt_reg + 1'b1;
                end
            end else begin
                cnt_reg <= '0;
            end
        end
    end

endmodule

// File: rtl/frec_selector.sv
// Push-button frequency selector: debounced up/down buttons with auto-repeat
// drive a saturating frecnum register; a sequential double-dabble converter
// keeps a BCD copy for the display.
module frec_selector
    import frec_selector_pkg::*;
#(
    parameter int unsigned       DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned       REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int unsigned       REPEAT_RATE     = DEF_REPEAT_RATE,
    parameter logic [FREC_W-1:0] FREC_MIN        = 8'd1,
    parameter logic [FREC_W-1:0] FREC_MAX        = 8'd200,
    parameter logic [FREC_W-1:0] FREC_RESET      = 8'd1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              btn_up,
    input  logic              btn_down,
    output logic [FREC_W-1:0] frecnum,
    output logic              frec_changed,
    output logic [BCD_W-1:0]  bcd_hund,
    output logic [BCD_W-1:0]  bcd_tens,
    output logic [BCD_W-1:0]  bcd_units,
    output logic              bcd_valid
);

    localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int          RPT_W   = $clog2(RPT_MAX + 1);
    localparam logic [RPT_W-1:0] DELAY_LAST = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] RATE_LAST  = RPT_W'(REPEAT_RATE - 1);
    localparam logic [2:0]       BIT_LAST   = 3'(FREC_W - 1);

    // Index 0 is the up button, index 1 the down button
    logic [1:0] btn_raw;
    logic [1:0] level;
    logic [1:0] rise;
    logic [1:0] step;
    logic       both;

    assign btn_raw = {btn_down, btn_up};
    assign both    = &level;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_btn
            logic             active_reg;
            logic             repeating_reg;
            logic [RPT_W-1:0] timer_reg;
            logic             hit;

            btn_debounce #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_debounce (
                .clk   (clk),
                .reset (reset),
                .btn   (btn_raw[gi]),
                .level (level[gi]),
                .rise  (rise[gi])
            );

            assign hit      = (timer_reg == (repeating_reg ? RATE_LAST : DELAY_LAST));
            assign step[gi] = !both && (rise[gi] || (active_reg && level[gi] && hit));

            // Auto-repeat timer: armed only by a fresh press, cleared by release or by
            // both buttons being down, so a leftover held button never resumes stepping
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    active_reg    <= 1'b0;
                    repeating_reg <= 1'b0;
                    timer_reg     <= '0;
                end else if (both) begin
                    active_reg    <= 1'b0;
                    repeating_reg <= 1'b0;
                    timer_reg     <= '0;
                end else if (rise[gi]) begin
                    active_reg    <= 1'b1;
                    repeating_reg <= 1'b0;
                    timer_reg     <= '0;
                end else if (active_reg && level[gi]) begin
                    if (hit) begin
                        timer_reg     <= '0;
                        repeating_reg <= 1'b1;
                    end else begin
                        timer_reg <= timer_reg + 1'b1;
                    end
                end else begin
                    active_reg    <= 1'b0;
                    repeating_reg <= 1'b0;
                    timer_reg     <= '0;
                end
            end
        end
    endgenerate

    // Saturating frequency code; frec_changed marks only real value changes
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frecnum      <= FREC_RESET;
            frec_changed <= 1'b0;
        end else begin
            frec_changed <= 1'b0;
            if (step[0] && (frecnum < FREC_MAX)) begin
                frecnum      <= frecnum + 8'd1;
                frec_changed <= 1'b1;
            end else if (step[1] && (frecnum > FREC_MIN)) begin
                frecnum      <= frecnum - 8'd1;
                frec_changed <= 1'b1;
            end
        end
    end

    // Double-dabble converter state
    bcd_state_t             state_reg;
    logic                   conv_pending_reg;
    logic [FREC_W-1:0]      bin_reg;
    logic [3*BCD_W-1:0]     scratch_reg;
    logic [3*BCD_W-1:0]     scratch_adj;
    logic [2:0]             bit_cnt_reg;

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_digit
            assign scratch_adj[gi*BCD_W +: BCD_W] = dabble_adjust(scratch_reg[gi*BCD_W +: BCD_W]);
        end
    endgenerate

    // BCD conversion FSM; outputs only change in DONE so the display never sees a partial value
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg        <= ST_IDLE;
            conv_pending_reg <= 1'b1;
            bin_reg          <= '0;
            scratch_reg      <= '0;
            bit_cnt_reg      <= '0;
            bcd_hund         <= '0;
            bcd_tens         <= '0;
            bcd_units        <= '0;
            bcd_valid        <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (conv_pending_reg) begin
                        conv_pending_reg <= 1'b0;
                        bcd_valid        <= 1'b0;
                        state_reg        <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    bin_reg     <= frecnum;
                    scratch_reg <= '0;
                    bit_cnt_reg <= '0;
                    state_reg   <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    {scratch_reg, bin_reg} <= {scratch_adj, bin_reg} << 1;
                    bit_cnt_reg            <= bit_cnt_reg + 3'd1;
                    if (bit_cnt_reg == BIT_LAST) begin
                        state_reg <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    bcd_hund  <= scratch_reg[2*BCD_W +: BCD_W];
                    bcd_tens  <= scratch_reg[BCD_W +: BCD_W];
                    bcd_units <= scratch_reg[0 +: BCD_W];
                    bcd_valid <= !(conv_pending_reg || frec_changed);
                    state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
            // A new value always invalidates the display copy and queues a conversion
            if (frec_changed) begin
                conv_pending_reg <= 1'b1;
                bcd_valid        <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_frec_selector.sv
// Directed testbench for frec_selector with shortened timing constants.
module tb_frec_selector;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       btn_up = 1'b0;
    logic       btn_down = 1'b0;
    logic [7:0] frecnum;
    logic       frec_changed;
    logic [3:0] bcd_hund;
    logic [3:0] bcd_tens;
    logic [3:0] bcd_units;
    logic       bcd_valid;

    int passed = 0;
    int total = 0;
    int cycle = 0;
    int pulse_cnt = 0;
    int pulse_cycle[$];

    always #5 clk = ~clk;

    frec_selector #(
        .DEBOUNCE_CYCLES(4),
        .REPEAT_DELAY(20),
        .REPEAT_RATE(5),
        .FREC_MIN(8'd1),
        .FREC_MAX(8'd200),
        .FREC_RESET(8'd1)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .btn_up       (btn_up),
        .btn_down     (btn_down),
        .frecnum      (frecnum),
        .frec_changed (frec_changed),
        .bcd_hund     (bcd_hund),
        .bcd_tens     (bcd_tens),
        .bcd_units    (bcd_units),
        .bcd_valid    (bcd_valid)
    );

    // Count frec_changed cycles (a two-cycle pulse counts twice) and note when they happen
    always @(negedge clk) begin
        cycle = cycle + 1;
        if (frec_changed === 1'b1) begin
            pulse_cnt = pulse_cnt + 1;
            pulse_cycle.push_back(cycle);
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        btn_up = 1'b0;
        btn_down = 1'b0;
        tick(3);
        reset = 1'b0;
        tick(15);
    endtask

    task automatic test_reset();
        int n;
        tick(2);
        total++;
        if ({frecnum, frec_changed, bcd_hund, bcd_tens, bcd_units, bcd_valid} !== {8'd1, 1'b0, 12'h000, 1'b0})
            $display("FAIL reset_state got f=%0d c=%b bcd=%h%h%h v=%b exp f=1 c=0 bcd=000 v=0",
                     frecnum, frec_changed, bcd_hund, bcd_tens, bcd_units, bcd_valid);
        else passed++;
        reset = 1'b0;
        n = 0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            n = i;
            if (bcd_valid === 1'b1) break;
        end
        total++;
        if (bcd_valid !== 1'b1) $display("FAIL reset_bcd_valid got v=%b after %0d cycles exp 1 within 12", bcd_valid, n);
        else passed++;
        total++;
        if ({bcd_hund, bcd_tens, bcd_units} !== 12'h001 || frecnum !== 8'd1)
            $display("FAIL reset_bcd got f=%0d bcd=%h%h%h exp f=1 bcd=001", frecnum, bcd_hund, bcd_tens, bcd_units);
        else passed++;
        $display("test_reset: frecnum=%0d bcd=%h%h%h valid after %0d cycles", frecnum, bcd_hund, bcd_tens, bcd_units, n);
    endtask

    task automatic test_bounce();
        int base;
        base = pulse_cnt;
        btn_up = 1'b1; tick(2);
        btn_up = 1'b0; tick(2);
        btn_up = 1'b1; tick(6);
        btn_up = 1'b0; tick(20);
        total++;
        if (pulse_cnt - base !== 1) $display("FAIL bounce_pulses got %0d exp 1", pulse_cnt - base);
        else passed++;
        total++;
        if (frecnum !== 8'd2) $display("FAIL bounce_frecnum got %0d exp 2", frecnum);
        else passed++;
        $display("test_bounce: frecnum=%0d pulses=%0d", frecnum, pulse_cnt - base);
    endtask

    task automatic test_repeat();
        int base;
        int qb;
        do_reset();
        base = pulse_cnt;
        qb = pulse_cycle.size();
        btn_up = 1'b1;
        tick(6);
        total++;
        if (frec_changed !== 1'b0 || frecnum !== 8'd1)
            $display("FAIL repeat_early got f=%0d c=%b exp f=1 c=0", frecnum, frec_changed);
        else passed++;
        tick(1);
        total++;
        if (frec_changed !== 1'b1 || frecnum !== 8'd2)
            $display("FAIL repeat_latency got f=%0d c=%b exp f=2 c=1", frecnum, frec_changed);
        else passed++;
        tick(31);
        btn_up = 1'b0;
        tick(30);
        total++;
        if (pulse_cnt - base !== 5 || frecnum !== 8'd6)
            $display("FAIL repeat_count got pulses=%0d f=%0d exp pulses=5 f=6", pulse_cnt - base, frecnum);
        else passed++;
        total++;
        if (pulse_cycle.size() < qb + 5) $display("FAIL repeat_gaps got %0d pulses exp 5", pulse_cycle.size() - qb);
        else if (pulse_cycle[qb+1] - pulse_cycle[qb] !== 20 || pulse_cycle[qb+2] - pulse_cycle[qb+1] !== 5 ||
                 pulse_cycle[qb+3] - pulse_cycle[qb+2] !== 5 || pulse_cycle[qb+4] - pulse_cycle[qb+3] !== 5)
            $display("FAIL repeat_gaps got %0d,%0d,%0d,%0d exp 20,5,5,5",
                     pulse_cycle[qb+1] - pulse_cycle[qb], pulse_cycle[qb+2] - pulse_cycle[qb+1],
                     pulse_cycle[qb+3] - pulse_cycle[qb+2], pulse_cycle[qb+4] - pulse_cycle[qb+3]);
        else passed++;
        $display("test_repeat: frecnum=%0d pulses=%0d", frecnum, pulse_cnt - base);
    endtask

    task automatic test_saturate();
        int base;
        do_reset();
        base = pulse_cnt;
        btn_up = 1'b1; tick(1100);
        total++;
        if (frecnum !== 8'd200 || pulse_cnt - base !== 199)
            $display("FAIL sat_max got f=%0d pulses=%0d exp f=200 pulses=199", frecnum, pulse_cnt - base);
        else passed++;
        btn_up = 1'b0; tick(15);
        base = pulse_cnt;
        btn_up = 1'b1; tick(8);
        btn_up = 1'b0; tick(15);
        total++;
        if (frecnum !== 8'd200 || pulse_cnt - base !== 0)
            $display("FAIL sat_up_at_max got f=%0d pulses=%0d exp f=200 pulses=0", frecnum, pulse_cnt - base);
        else passed++;
        btn_down = 1'b1; tick(8);
        btn_down = 1'b0; tick(15);
        total++;
        if (frecnum !== 8'd199 || pulse_cnt - base !== 1)
            $display("FAIL sat_down_from_max got f=%0d pulses=%0d exp f=199 pulses=1", frecnum, pulse_cnt - base);
        else passed++;
        do_reset();
        base = pulse_cnt;
        btn_down = 1'b1; tick(8);
        btn_down = 1'b0; tick(15);
        total++;
        if (frecnum !== 8'd1 || pulse_cnt - base !== 0)
            $display("FAIL sat_down_at_min got f=%0d pulses=%0d exp f=1 pulses=0", frecnum, pulse_cnt - base);
        else passed++;
        $display("test_saturate: frecnum=%0d", frecnum);
    endtask

    task automatic test_both_and_bcd();
        int base;
        logic valid_seen;
        do_reset();
        base = pulse_cnt;
        btn_up = 1'b1; btn_down = 1'b1; tick(30);
        total++;
        if (frecnum !== 8'd1 || pulse_cnt - base !== 0)
            $display("FAIL both_held got f=%0d pulses=%0d exp f=1 pulses=0", frecnum, pulse_cnt - base);
        else passed++;
        btn_down = 1'b0; tick(30);
        total++;
        if (frecnum !== 8'd1 || pulse_cnt - base !== 0)
            $display("FAIL both_no_resume got f=%0d pulses=%0d exp f=1 pulses=0", frecnum, pulse_cnt - base);
        else passed++;
        btn_up = 1'b0; tick(15);
        for (int k = 0; k < 98; k++) begin
            btn_up = 1'b1; tick(8);
            btn_up = 1'b0; tick(10);
        end
        tick(15);
        total++;
        if (frecnum !== 8'd99 || {bcd_hund, bcd_tens, bcd_units} !== 12'h099 || bcd_valid !== 1'b1)
            $display("FAIL bcd_99 got f=%0d bcd=%h%h%h v=%b exp f=99 bcd=099 v=1",
                     frecnum, bcd_hund, bcd_tens, bcd_units, bcd_valid);
        else passed++;
        base = pulse_cnt;
        btn_up = 1'b1; tick(6);
        btn_up = 1'b0; tick(1);
        total++;
        if (frec_changed !== 1'b1 || frecnum !== 8'd100)
            $display("FAIL step_100 got f=%0d c=%b exp f=100 c=1", frecnum, frec_changed);
        else passed++;
        tick(1);
        total++;
        if (bcd_valid !== 1'b0 || {bcd_hund, bcd_tens, bcd_units} !== 12'h099)
            $display("FAIL bcd_drop got v=%b bcd=%h%h%h exp v=0 bcd=099", bcd_valid, bcd_hund, bcd_tens, bcd_units);
        else passed++;
        tick(2);
        btn_up = 1'b1; tick(6);
        btn_up = 1'b0;
        valid_seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if ({bcd_hund, bcd_tens, bcd_units} !== 12'h099) break;
            if (bcd_valid === 1'b1) valid_seen = 1'b1;
            @(negedge clk);
        end
        total++;
        if ({bcd_hund, bcd_tens, bcd_units} !== 12'h100 || bcd_valid !== 1'b0 || valid_seen !== 1'b0)
            $display("FAIL bcd_mid got bcd=%h%h%h v=%b early_valid=%b exp bcd=100 v=0 early_valid=0",
                     bcd_hund, bcd_tens, bcd_units, bcd_valid, valid_seen);
        else passed++;
        for (int i = 0; i < 40; i++) begin
            if (bcd_valid === 1'b1) break;
            @(negedge clk);
        end
        total++;
        if ({bcd_hund, bcd_tens, bcd_units} !== 12'h101 || bcd_valid !== 1'b1 || frecnum !== 8'd101)
            $display("FAIL bcd_final got f=%0d bcd=%h%h%h v=%b exp f=101 bcd=101 v=1",
                     frecnum, bcd_hund, bcd_tens, bcd_units, bcd_valid);
        else passed++;
        tick(10);
        total++;
        if (pulse_cnt - base !== 2) $display("FAIL double_step_pulses got %0d exp 2", pulse_cnt - base);
        else passed++;
        $display("test_both_and_bcd: frecnum=%0d bcd=%h%h%h", frecnum, bcd_hund, bcd_tens, bcd_units);
    endtask

    task automatic test_reset_mid();
        int base;
        do_reset();
        btn_up = 1'b1;
        tick(35);
        total++;
        if (frecnum !== 8'd4) $display("FAIL mid_pre_reset got f=%0d exp 4", frecnum);
        else passed++;
        #2;
        reset = 1'b1;
        btn_up = 1'b0;
        #1;
        total++;
        if ({frecnum, frec_changed, bcd_hund, bcd_tens, bcd_units, bcd_valid} !== {8'd1, 1'b0, 12'h000, 1'b0})
            $display("FAIL mid_async_reset got f=%0d c=%b bcd=%h%h%h v=%b exp f=1 c=0 bcd=000 v=0",
                     frecnum, frec_changed, bcd_hund, bcd_tens, bcd_units, bcd_valid);
        else passed++;
        tick(3);
        reset = 1'b0;
        base = pulse_cnt;
        tick(40);
        total++;
        if (frecnum !== 8'd1 || pulse_cnt - base !== 0 || {bcd_hund, bcd_tens, bcd_units} !== 12'h001 || bcd_valid !== 1'b1)
            $display("FAIL mid_after_reset got f=%0d pulses=%0d bcd=%h%h%h v=%b exp f=1 pulses=0 bcd=001 v=1",
                     frecnum, pulse_cnt - base, bcd_hund, bcd_tens, bcd_units, bcd_valid);
        else passed++;
        $display("test_reset_mid: frecnum=%0d bcd=%h%h%h", frecnum, bcd_hund, bcd_tens, bcd_units);
    endtask

    initial begin
        test_reset();
        test_bounce();
        test_repeat();
        test_saturate();
        test_both_and_bcd();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
